// File: rtl/adpcm_pkg.sv
// ---------------------------------------------------------------------------
// adpcm_pkg
// Shared constants for the ADPCM filter stages: tap count, array address
// width, final shift, FSM state encoding and the locking key expected by the
// zero-section filter.
// ---------------------------------------------------------------------------
package adpcm_pkg;

   localparam int N_TAPS = 6;
   localparam int ADDR_W = 3;
   localparam int SHIFT  = 14;

   // Key that makes filtez_lock compute the true filter.
   localparam logic [3:0] FILTEZ_KEY_OK = 4'b0101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOOP = 2'd1,
      ST_DONE = 2'd2
   } filt_state_e;

endpackage

// File: rtl/adpcm_mac32.sv
// ---------------------------------------------------------------------------
// adpcm_mac32
// Signed 32x32 multiply feeding a registered 64-bit accumulator that can add
// or subtract the product. The accumulator wraps silently.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clr_i           load accumulator with zero (wins over en_i)
//   en_i            accumulate a_i*b_i this cycle
//   sub_i           1: subtract product, 0: add product
//   a_i, b_i        signed operands
//   acc_next_o      value the accumulator takes if en_i is high this cycle
// ---------------------------------------------------------------------------
module adpcm_mac32 (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic               sub_i,
   input  logic signed [31:0] a_i,
   input  logic signed [31:0] b_i,
   output logic signed [63:0] acc_next_o
);

   logic signed [63:0] prod;
   logic signed [63:0] acc_q, acc_d;

   // Both operands are signed, so they are sign-extended into the 64-bit
   // context before multiplying.
   assign prod       = a_i * b_i;
   assign acc_next_o = sub_i ? (acc_q - prod) : (acc_q + prod);

   always_comb begin
      acc_d = acc_q;
      if (clr_i)     acc_d = '0;
      else if (en_i) acc_d = acc_next_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) acc_q <= '0;
      else         acc_q <= acc_d;
   end

endmodule

// File: rtl/filtez_lock.sv
// ---------------------------------------------------------------------------
// filtez_lock
// Zero-section FIR of the ADPCM codec: sum(bpl[i]*dlt[i]) >>> SHIFT over the
// six taps written by the zero-coefficient update stage, read through two
// single-port ROM-style interfaces (data one cycle after ce0).
// A 4-bit key perturbs the datapath unless it equals the correct value.
// Ports:
//   ap_clk, ap_rst_n          clock, async active-low reset
//   ap_start                  start request, only sampled in IDLE
//   ap_done, ap_ready         one-cycle completion pulse
//   ap_idle                   high while in IDLE
//   bpl_address0/ce0/q0       coefficient array read port
//   dlt_address0/ce0/q0       delayed-difference array read port
//   ap_return                 registered signed result
//   working_key               locking key, static while busy
// ---------------------------------------------------------------------------
module filtez_lock #(
   parameter int N_TAPS = adpcm_pkg::N_TAPS,
   parameter int ADDR_W = adpcm_pkg::ADDR_W,
   parameter int SHIFT  = adpcm_pkg::SHIFT
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   output logic [ADDR_W-1:0] bpl_address0,
   output logic              bpl_ce0,
   input  logic [31:0]       bpl_q0,
   output logic [ADDR_W-1:0] dlt_address0,
   output logic              dlt_ce0,
   input  logic [31:0]       dlt_q0,
   output logic [31:0]       ap_return,
   input  logic [3:0]        working_key
);

   import adpcm_pkg::*;

   // One extra bit so the index can reach N_TAPS itself.
   localparam logic [ADDR_W:0] BOUND_FULL = (ADDR_W+1)'(N_TAPS);

   filt_state_e        state_q, state_d;
   logic [ADDR_W:0]    idx_q, idx_d;
   logic [31:0]        ret_q, ret_d;
   logic [ADDR_W:0]    bound;
   logic               rd_ce;
   logic [ADDR_W-1:0]  rd_addr;
   logic               mac_clr, mac_en;
   logic signed [31:0] bpl_s, dlt_s, bpl_term;
   logic signed [63:0] acc_next, acc_shr;

   // Key-controlled datapath variants; the correct key selects the plain
   // filter on every bit.
   assign bpl_s    = $signed(bpl_q0);
   assign dlt_s    = $signed(dlt_q0);
   assign bpl_term = working_key[0] ? bpl_s : (bpl_s + dlt_s);
   assign bound    = working_key[3] ? (BOUND_FULL - 1'b1) : BOUND_FULL;
   assign acc_shr  = working_key[2] ? (acc_next >>> SHIFT) : (acc_next >>> (SHIFT - 1));

   adpcm_mac32 u_mac (
      .clk_i      (ap_clk),
      .rst_ni     (ap_rst_n),
      .clr_i      (mac_clr),
      .en_i       (mac_en),
      .sub_i      (working_key[1]),
      .a_i        (bpl_term),
      .b_i        (dlt_s),
      .acc_next_o (acc_next)
   );

   // State register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (ap_start)        state_d = ST_LOOP;
         ST_LOOP: if (!(idx_q < bound)) state_d = ST_DONE;
         ST_DONE:                      state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   // Outputs and datapath controls
   always_comb begin
      ap_idle  = 1'b0;
      ap_done  = 1'b0;
      ap_ready = 1'b0;
      rd_ce    = 1'b0;
      rd_addr  = '0;
      idx_d    = idx_q;
      ret_d    = ret_q;
      mac_clr  = 1'b0;
      mac_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ap_idle = 1'b1;
            // Gate with reset so the read ports stay quiet while held in reset.
            if (ap_start && ap_rst_n) begin
               rd_ce   = 1'b1;
               mac_clr = 1'b1;
               idx_d   = (ADDR_W+1)'(1);
            end
         end
         ST_LOOP: begin
            // q0 carries the pair fetched last cycle (index idx_q-1).
            mac_en = 1'b1;
            if (idx_q < bound) begin
               rd_ce   = 1'b1;
               rd_addr = idx_q[ADDR_W-1:0];
               idx_d   = idx_q + 1'b1;
            end else begin
               // Last tap: capture the shifted sum including this product.
               ret_d = acc_shr[31:0];
            end
         end
         ST_DONE: begin
            ap_done  = 1'b1;
            ap_ready = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         idx_q <= '0;
         ret_q <= '0;
      end else begin
         idx_q <= idx_d;
         ret_q <= ret_d;
      end
   end

   assign bpl_ce0      = rd_ce;
   assign dlt_ce0      = rd_ce;
   assign bpl_address0 = rd_addr;
   assign dlt_address0 = rd_addr;
   assign ap_return    = ret_q;

endmodule

// File: tb/tb_filtez_lock.sv
module tb_filtez_lock;
   import adpcm_pkg::*;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        ap_start = 1'b0;
   logic        ap_done, ap_idle, ap_ready;
   logic [2:0]  bpl_address0, dlt_address0;
   logic        bpl_ce0, dlt_ce0;
   logic [31:0] bpl_q0 = '0, dlt_q0 = '0;
   logic [31:0] ap_return;
   logic [3:0]  working_key = FILTEZ_KEY_OK;

   int tests = 0;
   int fails = 0;
   int addr_err = 0;
   int addr_log[$];

   logic [31:0] bpl_mem [8];
   logic [31:0] dlt_mem [8];

   typedef struct packed {
      logic [3:0]       key;
      logic [5:0][31:0] bpl;
      logic [5:0][31:0] dlt;
      logic [31:0]      ret;
      logic [7:0]       lat;
   } vec_t;

   vec_t vecs [6];

   filtez_lock dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .ap_start     (ap_start),
      .ap_done      (ap_done),
      .ap_idle      (ap_idle),
      .ap_ready     (ap_ready),
      .bpl_address0 (bpl_address0),
      .bpl_ce0      (bpl_ce0),
      .bpl_q0       (bpl_q0),
      .dlt_address0 (dlt_address0),
      .dlt_ce0      (dlt_ce0),
      .dlt_q0       (dlt_q0),
      .ap_return    (ap_return),
      .working_key  (working_key)
   );

   always #5 ap_clk = ~ap_clk;

   // Single-port ROMs with one cycle read latency.
   always @(posedge ap_clk) begin
      if (bpl_ce0) bpl_q0 <= bpl_mem[bpl_address0];
      if (dlt_ce0) dlt_q0 <= dlt_mem[dlt_address0];
      if (bpl_ce0) addr_log.push_back(int'(bpl_address0));
      if (bpl_ce0 !== dlt_ce0 || bpl_address0 !== dlt_address0) addr_err++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic load(input logic [5:0][31:0] b, input logic [5:0][31:0] d);
      for (int i = 0; i < 6; i++) begin
         bpl_mem[i] = b[i];
         dlt_mem[i] = d[i];
      end
      // Out-of-range entries hold junk so stray reads would corrupt the sum.
      bpl_mem[6] = 32'h1234_5678; bpl_mem[7] = 32'h7777_0001;
      dlt_mem[6] = 32'h0BAD_0001; dlt_mem[7] = 32'h0000_3333;
   endtask

   // One start pulse; returns result and the cycle (start cycle = 0) of ap_done.
   task automatic run(input logic [3:0] key, output logic [31:0] ret, output int lat);
      int cyc;
      working_key = key;
      addr_log.delete();
      @(negedge ap_clk);
      chk("idle_before_start", ap_idle, 1'b1);
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      cyc = 1;
      while (ap_done !== 1'b1 && cyc < 40) begin
         @(negedge ap_clk);
         cyc++;
      end
      chk("done_seen", ap_done, 1'b1);
      chk("ready_with_done", ap_ready, ap_done);
      lat = cyc;
      ret = ap_return;
      @(negedge ap_clk);
      chk("done_one_cycle", ap_done, 1'b0);
      chk("idle_after_done", ap_idle, 1'b1);
   endtask

   // Reference: the filter as written in arithmetic terms.
   function automatic logic [31:0] ref_filt(input logic [3:0] key,
                                            input logic [5:0][31:0] b,
                                            input logic [5:0][31:0] d);
      longint acc;
      longint p;
      int     taps;
      int     bt;
      acc  = 0;
      taps = key[3] ? 5 : 6;
      for (int i = 0; i < taps; i++) begin
         bt  = key[0] ? int'(b[i]) : int'(b[i]) + int'(d[i]);
         p   = longint'(bt) * longint'(int'(d[i]));
         acc = key[1] ? acc - p : acc + p;
      end
      acc = acc >>> (key[2] ? 14 : 13);
      return acc[31:0];
   endfunction

   function automatic vec_t mk(input logic [3:0] key, input logic [31:0] ret, input logic [7:0] lat);
      vec_t v;
      v     = '0;
      v.key = key;
      v.ret = ret;
      v.lat = lat;
      return v;
   endfunction

   initial begin
      logic [31:0]      r;
      int               l;
      logic             ord;
      logic             seen;
      int               dc[$];
      logic [5:0][31:0] b, d;

      // ---- vector table ----
      vecs[0] = mk(4'b0101, 32'd6, 8'd7);
      for (int i = 0; i < 6; i++) begin vecs[0].bpl[i] = 32'h4000; vecs[0].dlt[i] = 32'd1; end
      vecs[1] = mk(4'b0101, 32'hFFFF_FFFD, 8'd7);
      vecs[1].bpl[0] = 32'hFFFF_C000; vecs[1].dlt[0] = 32'd3;
      vecs[2] = mk(4'b0101, 32'hFFFF_FFFF, 8'd7);
      vecs[2].bpl[0] = 32'hFFFF_FFFF; vecs[2].dlt[0] = 32'd1;
      vecs[3] = mk(4'b0101, 32'hFFFC_0000, 8'd7);
      vecs[3].bpl[5] = 32'h7FFF_FFFF; vecs[3].dlt[5] = 32'h7FFF_FFFF;
      vecs[4] = vecs[0]; vecs[4].key = 4'b1101; vecs[4].ret = 32'd5; vecs[4].lat = 8'd6;
      vecs[5] = vecs[0]; vecs[5].key = 4'b0000; vecs[5].ret = 32'd12;

      // ---- reset state ----
      #12;
      chk("rst_idle", ap_idle, 1'b1);
      chk("rst_done", ap_done, 1'b0);
      chk("rst_ready", ap_ready, 1'b0);
      chk("rst_ce", {bpl_ce0, dlt_ce0}, 2'b00);
      chk("rst_addr", {bpl_address0, dlt_address0}, 6'd0);
      chk("rst_ret", ap_return, 32'd0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;

      // ---- table-driven vectors ----
      for (int n = 0; n < 6; n++) begin
         load(vecs[n].bpl, vecs[n].dlt);
         run(vecs[n].key, r, l);
         chk($sformatf("vec%0d_ret", n), r, vecs[n].ret);
         chk($sformatf("vec%0d_lat", n), l, 32'(vecs[n].lat));
         chk($sformatf("vec%0d_naddr", n), addr_log.size(), 32'(vecs[n].lat) - 1);
         ord = 1'b1;
         foreach (addr_log[i]) if (addr_log[i] != i) ord = 1'b0;
         chk($sformatf("vec%0d_addr_order", n), ord, 1'b1);
      end

      // ---- reset in the third LOOP cycle ----
      load(vecs[0].bpl, vecs[0].dlt);
      working_key = FILTEZ_KEY_OK;
      @(negedge ap_clk);
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      @(negedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      #1;
      chk("midrst_idle", ap_idle, 1'b1);
      chk("midrst_ret", ap_return, 32'd0);
      chk("midrst_ce", bpl_ce0, 1'b0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge ap_clk);
         if (ap_done !== 1'b0) seen = 1'b1;
      end
      chk("midrst_no_done", seen, 1'b0);
      ap_rst_n = 1'b1;
      run(FILTEZ_KEY_OK, r, l);
      chk("after_rst_ret", r, 32'd6);
      chk("after_rst_lat", l, 32'd7);

      // ---- ap_start held high: back-to-back runs ----
      @(negedge ap_clk);
      ap_start = 1'b1;
      for (int c = 1; c <= 31; c++) begin
         @(negedge ap_clk);
         if (ap_done === 1'b1) begin
            dc.push_back(c);
            chk("held_ret", ap_return, 32'd6);
         end else if (dc.size() > 0) begin
            chk("held_stable", ap_return, 32'd6);
         end
      end
      ap_start = 1'b0;
      chk("held_pulses", dc.size(), 32'd4);
      foreach (dc[i]) chk($sformatf("held_done%0d_cycle", i), dc[i], 7 + 8 * i);
      @(negedge ap_clk);

      // ---- start pulses during LOOP are ignored ----
      for (int i = 0; i < 6; i++) begin b[i] = 32'h8000; d[i] = 32'd2; end
      load(b, d);
      addr_log.delete();
      @(negedge ap_clk);
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      for (int c = 2; c <= 7; c++) begin
         @(negedge ap_clk);
         ap_start = (c == 2 || c == 4 || c == 5);
         if (c == 6) chk("ign_no_early_done", ap_done, 1'b0);
      end
      chk("ign_done_c7", ap_done, 1'b1);
      chk("ign_ret", ap_return, 32'd24);
      seen = 1'b0;
      repeat (10) begin
         @(negedge ap_clk);
         if (ap_done !== 1'b0 || ap_idle !== 1'b1) seen = 1'b1;
      end
      chk("ign_no_rerun", seen, 1'b0);
      chk("ign_naddr", addr_log.size(), 32'd6);

      // ---- randomized runs against the reference ----
      for (int n = 0; n < 30; n++) begin
         logic [3:0] k;
         k = ($urandom_range(0, 3) == 0) ? 4'($urandom) : FILTEZ_KEY_OK;
         for (int i = 0; i < 6; i++) begin
            b[i] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 65535)) - 32'd32768;
            d[i] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 65535)) - 32'd32768;
         end
         load(b, d);
         run(k, r, l);
         chk($sformatf("rand%0d_ret_key%h", n, k), r, ref_filt(k, b, d));
         chk($sformatf("rand%0d_lat", n), l, k[3] ? 32'd6 : 32'd7);
      end

      chk("port_addr_agree", addr_err, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
